// File: rtl/dcache_2way.sv
// rtl/dcache_2way.sv - two-way set-associative write-back data cache with LRU replacement
//
// Purpose: CPU-side word cache in front of a block-wide memory. Hits are
// served combinationally. A miss runs IDLE -> [WRITEBACK] -> FETCH -> FILL -> IDLE,
// and the cycle after FILL the still-held request hits.
//
// Ports:
//   CLK, RESET           clock, asynchronous active-low reset
//   readEn, writeEn      CPU request (both high means write), held while busy
//   address, dataIn      CPU word address {tag,index,offset}, write data
//   dataOut, busy        read-hit data (0 otherwise), CPU stall
//   readM, writeM        memory block read / write-back request
//   dataMaddress         memory block address {tag,index}
//   dataToM, dataFromM   write-back block, fetched block
//   busyMem              memory busy; a request completes on a posedge with it low
module dcache_2way #(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 3
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              readEn,
  input  logic                              writeEn,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [WORD_W-1:0]                 dataIn,
  output logic [WORD_W-1:0]                 dataOut,
  output logic                              busy,
  output logic                              readM,
  output logic                              writeM,
  output logic [ADDR_W-OFFSET_W-1:0]        dataMaddress,
  output logic [(WORD_W<<OFFSET_W)-1:0]     dataToM,
  input  logic [(WORD_W<<OFFSET_W)-1:0]     dataFromM,
  input  logic                              busyMem
);

  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam int BLK_W = WORD_W << OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_FILL} state_t;

  state_t                r_state;
  logic                  r_valid [0:1][0:SETS-1];
  logic                  r_dirty [0:1][0:SETS-1];
  logic [TAG_W-1:0]      r_tag   [0:1][0:SETS-1];
  logic [BLK_W-1:0]      r_data  [0:1][0:SETS-1];
  logic                  r_lru   [0:SETS-1];

  // Miss context latched on leaving IDLE so the sequence can finish even if
  // the CPU drops or changes its request.
  logic                  r_vway;
  logic [INDEX_W-1:0]    r_idx;
  logic [TAG_W-1:0]      r_rtag;
  logic [BLK_W-1:0]      r_fill;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_idx;
  logic [OFFSET_W-1:0]   w_off;
  logic                  w_req, w_m0, w_m1, w_hit0, w_hit1, w_hit, w_way;
  logic                  w_vway, w_vdirty;
  logic [BLK_W-1:0]      w_blk;

  assign w_tag = address[ADDR_W-1 -: TAG_W];
  assign w_idx = address[OFFSET_W +: INDEX_W];
  assign w_off = address[OFFSET_W-1:0];
  assign w_req = readEn | writeEn;

  assign w_m0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_m1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);

  // Hits are only taken in IDLE so a hit can never race the victim being
  // written back or filled; during a miss no filled tag can match anyway.
  assign w_hit0 = w_req && (r_state == S_IDLE) && w_m0;
  assign w_hit1 = w_req && (r_state == S_IDLE) && w_m1 && !w_m0;
  assign w_hit  = w_hit0 | w_hit1;
  assign w_way  = w_hit1;

  assign w_blk   = w_way ? r_data[1][w_idx] : r_data[0][w_idx];
  assign busy    = w_req & ~w_hit;
  assign dataOut = (w_hit && !writeEn) ? w_blk[w_off*WORD_W +: WORD_W] : '0;

  // Victim: first invalid way (way 0 preferred), otherwise the LRU way.
  assign w_vway   = !r_valid[0][w_idx] ? 1'b0 :
                    !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
  assign w_vdirty = r_valid[w_vway][w_idx] & r_dirty[w_vway][w_idx];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[0][s] <= 1'b0;
        r_valid[1][s] <= 1'b0;
        r_dirty[0][s] <= 1'b0;
        r_dirty[1][s] <= 1'b0;
        r_lru[s]      <= 1'b0;
      end
      r_state      <= S_IDLE;
      readM        <= 1'b0;
      writeM       <= 1'b0;
      dataMaddress <= '0;
      dataToM      <= '0;
      r_vway       <= 1'b0;
      r_idx        <= '0;
      r_rtag       <= '0;
      r_fill       <= '0;
    end else begin
      if (w_hit) begin
        r_lru[w_idx] <= ~w_way;
        if (writeEn) r_dirty[w_way][w_idx] <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_vway <= w_vway;
            r_idx  <= w_idx;
            r_rtag <= w_tag;
            if (w_vdirty) begin
              r_state      <= S_WRITEBACK;
              writeM       <= 1'b1;
              dataMaddress <= {r_tag[w_vway][w_idx], w_idx};
              dataToM      <= r_data[w_vway][w_idx];
            end else begin
              r_state      <= S_FETCH;
              readM        <= 1'b1;
              dataMaddress <= {w_tag, w_idx};
            end
          end
        end
        S_WRITEBACK: begin
          if (!busyMem) begin
            r_state      <= S_FETCH;
            writeM       <= 1'b0;
            dataToM      <= '0;
            readM        <= 1'b1;
            dataMaddress <= {r_rtag, r_idx};
          end
        end
        S_FETCH: begin
          if (!busyMem) begin
            r_state      <= S_FILL;
            readM        <= 1'b0;
            dataMaddress <= '0;
            r_fill       <= dataFromM;
          end
        end
        S_FILL: begin
          r_valid[r_vway][r_idx] <= 1'b1;
          r_dirty[r_vway][r_idx] <= 1'b0;
          r_state                <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and block storage need no reset; valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (w_hit && writeEn) r_data[w_way][w_idx][w_off*WORD_W +: WORD_W] <= dataIn;
    if (r_state == S_FILL) begin
      r_data[r_vway][r_idx] <= r_fill;
      r_tag[r_vway][r_idx]  <= r_rtag;
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// tb/tb_dcache_2way.sv - self-checking bench for dcache_2way
module tb_dcache_2way;

  logic        CLK = 1'b0;
  logic        RESET, readEn, writeEn, busyMem;
  logic [7:0]  address, dataIn;
  logic [7:0]  dataOut;
  logic        busy, readM, writeM;
  logic [5:0]  dataMaddress;
  logic [31:0] dataToM, dataFromM;

  always #5 CLK = ~CLK;

  dcache_2way dut (
    .CLK(CLK), .RESET(RESET), .readEn(readEn), .writeEn(writeEn),
    .address(address), .dataIn(dataIn), .dataOut(dataOut), .busy(busy),
    .readM(readM), .writeM(writeM), .dataMaddress(dataMaddress),
    .dataToM(dataToM), .dataFromM(dataFromM), .busyMem(busyMem)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_blk [0:63];
  logic [7:0]  ref_word [0:255];
  logic [7:0]  exp_q [$];

  int          t_busy, t_rd, t_wr, t_wb_cycles;
  logic [5:0]  t_rd_addr, t_wb_addr;
  logic [31:0] t_wb_data;
  bit          t_unsteady;
  bit          t_both = 0;
  bit          t_idle_nonzero = 0;

  task automatic sync_ref();
    logic [31:0] blk;
    for (int i = 0; i < 256; i++) begin
      blk = mem_blk[i >> 2];
      ref_word[i] = blk[(i % 4) * 8 +: 8];
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input int wmax);
    logic [7:0] exp;
    int wcnt, guard;
    bit done, first_wb;
    t_busy = 0; t_rd = 0; t_wr = 0; t_wb_cycles = 0; t_unsteady = 0;
    t_rd_addr = '0; t_wb_addr = '0; t_wb_data = '0;
    if (wr) begin
      exp_q.push_back(8'h00);
      ref_word[a] = d;
    end else begin
      exp_q.push_back(ref_word[a]);
    end
    readEn = rd; writeEn = wr; address = a; dataIn = d; busyMem = 1'b0;
    wcnt = wmax; guard = 0; done = 0; first_wb = 1;
    while (!done) begin
      #1;
      if (readM && writeM) t_both = 1;
      if (!readM && !writeM && (dataMaddress != 0 || dataToM != 0)) t_idle_nonzero = 1;
      if (!busy) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (dataOut !== exp) begin
          n_fail++;
          $display("FAIL data addr=%h rd=%0b wr=%0b got %h expected %h", a, rd, wr, dataOut, exp);
        end
        done = 1;
      end else begin
        t_busy++;
        if (writeM) begin
          if (first_wb) begin
            t_wb_addr = dataMaddress; t_wb_data = dataToM; first_wb = 0;
          end else if (dataMaddress !== t_wb_addr || dataToM !== t_wb_data) begin
            t_unsteady = 1;
          end
          t_wb_cycles++;
        end
        if (readM || writeM) begin
          busyMem = (wcnt > 0);
          if (wcnt > 0) wcnt--;
          else begin
            wcnt = wmax;
            if (writeM) begin mem_blk[dataMaddress] = dataToM; t_wr++; end
            if (readM) begin dataFromM = mem_blk[dataMaddress]; t_rd_addr = dataMaddress; t_rd++; end
          end
        end else begin
          busyMem = 1'b0;
        end
      end
      @(negedge CLK);
      guard++;
      if (!done && guard > 200) begin
        n_checks++; n_fail++;
        $display("FAIL timeout addr=%h busy=%0b expected 0 within 200 cycles", a, busy);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        done = 1;
      end
    end
    readEn = 1'b0; writeEn = 1'b0; busyMem = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; readEn = 1'b0; writeEn = 1'b0; busyMem = 1'b0;
    address = '0; dataIn = '0; dataFromM = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dataOut got %h expected 00", dataOut); end
    n_checks++; if (readM !== 1'b0 || writeM !== 1'b0) begin n_fail++; $display("FAIL reset_mreq got %b%b expected 00", readM, writeM); end
    n_checks++; if (dataMaddress !== 6'h00 || dataToM !== 32'h0) begin n_fail++; $display("FAIL reset_mbus got %h/%h expected 0/0", dataMaddress, dataToM); end
    @(negedge CLK);
  endtask

  task automatic test_read_miss();
    access(1'b1, 1'b0, 8'h05, 8'h00, 0);
    n_checks++; if (t_busy !== 3) begin n_fail++; $display("FAIL miss_latency got %0d expected 3", t_busy); end
    n_checks++; if (t_rd !== 1 || t_wr !== 0) begin n_fail++; $display("FAIL miss_traffic got rd=%0d wr=%0d expected 1/0", t_rd, t_wr); end
    n_checks++; if (t_rd_addr !== 6'h01) begin n_fail++; $display("FAIL miss_maddr got %h expected 01", t_rd_addr); end
  endtask

  task automatic test_write_hit();
    access(1'b0, 1'b1, 8'h05, 8'h5A, 0);
    n_checks++; if (t_busy !== 0 || t_rd !== 0 || t_wr !== 0) begin n_fail++; $display("FAIL write_hit_stall got busy=%0d rd=%0d wr=%0d expected 0/0/0", t_busy, t_rd, t_wr); end
    access(1'b1, 1'b0, 8'h05, 8'h00, 0);
    n_checks++; if (t_busy !== 0) begin n_fail++; $display("FAIL read_hit_stall got %0d expected 0", t_busy); end
  endtask

  task automatic test_evict();
    access(1'b1, 1'b0, 8'h25, 8'h00, 0);
    n_checks++; if (t_rd !== 1 || t_wr !== 0 || t_rd_addr !== 6'h09) begin n_fail++; $display("FAIL fill_way1 got rd=%0d wr=%0d addr=%h expected 1/0/09", t_rd, t_wr, t_rd_addr); end
    access(1'b1, 1'b0, 8'h45, 8'h00, 0);
    n_checks++; if (t_wr !== 1 || t_wb_addr !== 6'h01) begin n_fail++; $display("FAIL evict_wb got wr=%0d addr=%h expected 1/01", t_wr, t_wb_addr); end
    n_checks++; if (t_wb_data !== 32'hDDCC5AAA) begin n_fail++; $display("FAIL evict_wb_data got %h expected DDCC5AAA", t_wb_data); end
    n_checks++; if (t_rd_addr !== 6'h11) begin n_fail++; $display("FAIL evict_fetch got %h expected 11", t_rd_addr); end
    access(1'b1, 1'b0, 8'h25, 8'h00, 0);
    n_checks++; if (t_busy !== 0) begin n_fail++; $display("FAIL way1_kept got busy=%0d expected 0", t_busy); end
  endtask

  task automatic test_wb_stall();
    logic [31:0] exp_blk;
    exp_blk = mem_blk[6'h11];
    exp_blk[23:16] = 8'h3C;
    access(1'b0, 1'b1, 8'h46, 8'h3C, 0);
    access(1'b1, 1'b0, 8'h26, 8'h00, 0);
    access(1'b1, 1'b0, 8'h05, 8'h00, 5);
    n_checks++; if (t_wb_cycles !== 6) begin n_fail++; $display("FAIL stall_wb_cycles got %0d expected 6", t_wb_cycles); end
    n_checks++; if (t_unsteady !== 1'b0) begin n_fail++; $display("FAIL stall_wb_steady got %b expected 0", t_unsteady); end
    n_checks++; if (t_wb_addr !== 6'h11 || t_wb_data !== exp_blk) begin n_fail++; $display("FAIL stall_wb_block got %h/%h expected 11/%h", t_wb_addr, t_wb_data, exp_blk); end
    n_checks++; if (t_busy !== 14) begin n_fail++; $display("FAIL stall_latency got %0d expected 14", t_busy); end
  endtask

  task automatic test_reset_fetch();
    @(negedge CLK);
    readEn = 1'b1; writeEn = 1'b0; address = 8'h85; busyMem = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_miss got %b expected 1", busy); end
    @(negedge CLK);
    #1;
    n_checks++; if (readM !== 1'b1 || dataMaddress !== 6'h21) begin n_fail++; $display("FAIL rst_fetch_req got %b/%h expected 1/21", readM, dataMaddress); end
    RESET = 1'b0;
    #1;
    n_checks++; if (readM !== 1'b0 || writeM !== 1'b0 || dataMaddress !== 6'h00) begin n_fail++; $display("FAIL rst_async_drop got %b%b/%h expected 00/00", readM, writeM, dataMaddress); end
    readEn = 1'b0;
    @(negedge CLK);
    RESET = 1'b1; busyMem = 1'b0;
    sync_ref();
    access(1'b1, 1'b0, 8'h85, 8'h00, 0);
    n_checks++; if (t_rd !== 1 || t_rd_addr !== 6'h21) begin n_fail++; $display("FAIL rst_remiss got rd=%0d addr=%h expected 1/21", t_rd, t_rd_addr); end
  endtask

  task automatic test_rw_both();
    access(1'b1, 1'b1, 8'h85, 8'h77, 0);
    n_checks++; if (t_busy !== 0 || t_rd !== 0) begin n_fail++; $display("FAIL rw_both_hit got busy=%0d rd=%0d expected 0/0", t_busy, t_rd); end
    access(1'b1, 1'b0, 8'h85, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic       wr;
    for (int k = 0; k < 40; k++) begin
      a  = {3'($urandom_range(0, 7)), 3'($urandom_range(1, 2)), 2'($urandom_range(0, 3))};
      wr = 1'($urandom_range(0, 1));
      access(~wr | 1'($urandom_range(0, 1)), wr, a, 8'($urandom), $urandom_range(0, 2));
    end
    n_checks++; if (t_both !== 1'b0) begin n_fail++; $display("FAIL mreq_exclusive got %b expected 0", t_both); end
    n_checks++; if (t_idle_nonzero !== 1'b0) begin n_fail++; $display("FAIL mbus_idle_zero got %b expected 0", t_idle_nonzero); end
  endtask

  initial begin
    for (int b = 0; b < 64; b++)
      mem_blk[b] = {8'(b*4+3) ^ 8'h5C, 8'(b*4+2) ^ 8'h5C, 8'(b*4+1) ^ 8'h5C, 8'(b*4) ^ 8'h5C};
    mem_blk[1] = 32'hDDCCBBAA;
    sync_ref();
    test_reset();
    test_read_miss();
    test_write_hit();
    test_evict();
    test_wb_stall();
    test_reset_fetch();
    test_rw_both();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the byte-address width.
REQ-002 The block SHALL have parameter WORD_W, default 8, meaning the CPU data width in bits.
REQ-003 The block SHALL have parameter OFFSET_W, default 2, meaning log2 of words per block, so 4 words per block.
REQ-004 The block SHALL have parameter INDEX_W, default 3, meaning log2 of the set count, so 8 sets of 2 ways; TAG_W = ADDR_W-OFFSET_W-INDEX_W and BLK_W = WORD_W<<OFFSET_W.
REQ-005 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on posedge.
REQ-006 The block SHALL have port RESET, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port readEn, input, 1 bit, CPU read request, held until busy is low at a posedge.
REQ-008 The block SHALL have port writeEn, input, 1 bit, CPU write request, held the same way as readEn.
REQ-009 The block SHALL have port address, input, ADDR_W bits, CPU word address: tag, then index, then offset.
REQ-010 The block SHALL have port dataIn, input, WORD_W bits, CPU write data.
REQ-011 The block SHALL have port dataOut, output, WORD_W bits, CPU read data.
REQ-012 The block SHALL have port busy, output, 1 bit, CPU stall.
REQ-013 The block SHALL have port readM, output, 1 bit, memory block read request.
REQ-014 The block SHALL have port writeM, output, 1 bit, memory block write request.
REQ-015 The block SHALL have port dataMaddress, output, ADDR_W-OFFSET_W bits, memory block address.
REQ-016 The block SHALL have port dataToM, output, BLK_W bits, write-back block data.
REQ-017 The block SHALL have port dataFromM, input, BLK_W bits, fetched block data.
REQ-018 The block SHALL have port busyMem, input, 1 bit, memory busy; a request completes at the first posedge where busyMem is low while the request is asserted.

Function
REQ-019 The block SHALL keep, per set and way, valid, dirty, tag and block storage, plus one LRU bit per set naming the least-recently-used way.
REQ-020 The block SHALL compute hit combinationally as (readEn|writeEn) with a valid way whose tag equals address tag; at most one way may hit.
REQ-021 The block SHALL drive busy = (readEn|writeEn) & !hit combinationally, so a hit never stalls.
REQ-022 On a read hit the block SHALL drive dataOut with the word selected by the offset in the same cycle; dataOut SHALL be 0 when there is no read hit.
REQ-023 On a write hit the block SHALL write dataIn into the selected word and set dirty at the posedge.
REQ-024 On every hit posedge the block SHALL set LRU to the way not accessed.
REQ-025 If readEn and writeEn are both high, the block SHALL treat the request as a write.
REQ-026 The FSM SHALL have states IDLE, WRITEBACK, FETCH and FILL.
REQ-027 The block SHALL choose the victim way in this order: an invalid way (way 0 first), else the LRU way; the victim SHALL be latched on leaving IDLE.
REQ-028 From IDLE on a miss, the FSM SHALL go to WRITEBACK if the victim is valid and dirty, else to FETCH.
REQ-029 In WRITEBACK the block SHALL assert writeM with dataMaddress={victim tag,index} and dataToM=victim block, and SHALL go to FETCH on completion.
REQ-030 In FETCH the block SHALL assert readM with dataMaddress={address tag,index}, SHALL capture dataFromM on completion, and SHALL go to FILL.
REQ-031 In FILL (one cycle) the block SHALL write the block, tag, valid=1 and dirty=0 to the victim, then return to IDLE; the next cycle hits and completes the request.
REQ-032 Outside WRITEBACK and FETCH, readM, writeM, dataMaddress and dataToM SHALL be 0; readM and writeM SHALL never be high together.
REQ-033 If the request drops mid-miss, the block SHALL still complete the current state sequence and SHALL NOT update LRU or data.
REQ-034 Miss latency for a clean miss with zero-wait memory SHALL be 3 posedges (FETCH, FILL, hit).

Reset
REQ-035 When RESET is low, the block SHALL immediately clear all valid, dirty and LRU bits, set the state to IDLE, and force readM, writeM, dataMaddress and dataToM to 0; any in-flight memory request SHALL be abandoned.
REQ-036 After reset, the block SHALL leave busy and dataOut as their combinational functions of the inputs; with no request, both SHALL be 0.

Verification
REQ-037 Scenario: reset, then read 0x05 with memory block 0x01 = 0xDDCCBBAA -> busy high, readM with dataMaddress 0x01, then dataOut 0xBB and busy low.
REQ-038 Scenario: write 0x5A to 0x05, then read 0x05 -> both hit with no memory traffic, dataOut 0x5A, way dirty.
REQ-039 Scenario: read 0x05, 0x25, then 0x45 (same set 1) -> the first two fill way 0 and way 1 with no eviction; 0x45 evicts the LRU way (way 0 holding tag 0), with writeback of block 0x01 only if dirty.
REQ-040 Scenario: dirty victim with busyMem held high for 5 cycles -> writeM held steady the whole time, readM low until writeback completes.
REQ-041 Scenario: assert RESET during FETCH -> readM drops asynchronously, state is IDLE, and a following read to the same address misses again.
REQ-042 Scenario: readEn and writeEn both high on a hit -> a write occurs and dataOut is 0.
